vc_switch_arbiter: RTL

- Output-port scheduler for the virtual channel router.
- Shares one 32-bit output link between NUM_VC input VC FIFOs that are filled by the input flow controllers.
- Uses round-robin packet-level (wormhole) arbitration with per-downstream-VC credit counting.
- Pops the granted FIFO and drives a registered flit, its VC id and a valid strobe onto the link.

---
 rtl/vc_switch_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/vc_switch_arbiter.sv
// Output-port scheduler: round-robin wormhole arbitration of NUM_VC input FIFOs
// onto one 32-bit link, with per-VC downstream credit counting.
module vc_switch_arbiter #(
    parameter int unsigned NUM_VC       = 4,
    parameter int unsigned VC_W         = 2,
    parameter int unsigned CREDIT_DEPTH = 8,
    parameter int unsigned CNT_W        = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_VC-1:0]      vc_empty,
    input  logic [32*NUM_VC-1:0]   vc_data,
    output logic [NUM_VC-1:0]      rd_en,
    input  logic                   credit_val,
    input  logic [VC_W-1:0]        credit_vc,
    output logic                   out_val,
    output logic [31:0]            out_data,
    output logic [VC_W-1:0]        out_vc,
    output logic                   err
);

    localparam logic [1:0] FT_HEAD = 2'b01;
    localparam logic [1:0] FT_TAIL = 2'b10;

    typedef enum logic {StIdle, StBusy} state_e;

    state_e           r_state;
    logic [VC_W-1:0]  r_gnt;
    logic [VC_W-1:0]  r_rr_ptr;
    logic [CNT_W-1:0] r_credit [NUM_VC];
    logic             r_out_val;
    logic [31:0]      r_out_data;
    logic [VC_W-1:0]  r_out_vc;
    logic             r_err;

    logic [NUM_VC-1:0] w_elig;
    logic [NUM_VC-1:0] w_head;
    logic              w_win_found;
    logic [VC_W-1:0]   w_win;
    int unsigned       w_idx;
    logic              w_disc_found;
    logic [VC_W-1:0]   w_disc;
    logic              w_pop_busy;
    logic [31:0]       w_pop_flit;
    logic [VC_W-1:0]   w_gnt_next;
    logic [NUM_VC-1:0] w_rd_en;
    logic [NUM_VC-1:0] w_cred_inc;
    logic [NUM_VC-1:0] w_cred_dec;
    logic              w_cred_ovf;
    logic              w_err_next;

    // Per-VC eligibility and head-flit detection
    always_comb begin
        w_elig = '0;
        w_head = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            w_elig[i] = !vc_empty[i] && (r_credit[i] != '0);
            w_head[i] = (vc_data[32*i+29 +: 2] == FT_HEAD);
        end
    end

    // Round-robin search for a head flit starting at r_rr_ptr, and the lowest-index
    // stray non-head flit to discard while idle
    always_comb begin
        w_win_found  = 1'b0;
        w_win        = '0;
        w_idx        = 0;
        w_disc_found = 1'b0;
        w_disc       = '0;
        for (int k = 0; k < NUM_VC; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NUM_VC) w_idx = w_idx - NUM_VC;
            if (!w_win_found && w_elig[w_idx] && w_head[w_idx]) begin
                w_win_found = 1'b1;
                w_win       = VC_W'(w_idx);
            end
        end
        for (int i = NUM_VC - 1; i >= 0; i--) begin
            if (!vc_empty[i] && !w_head[i]) begin
                w_disc_found = 1'b1;
                w_disc       = VC_W'(i);
            end
        end
    end

    assign w_pop_busy = (r_state == StBusy) && w_elig[r_gnt];
    assign w_pop_flit = vc_data[32*r_gnt +: 32];
    assign w_gnt_next = (r_gnt == VC_W'(NUM_VC - 1)) ? '0 : r_gnt + 1'b1;

    // Pop strobes, credit update requests and the error condition
    always_comb begin
        w_rd_en    = '0;
        w_cred_inc = '0;
        w_cred_dec = '0;
        w_cred_ovf = 1'b0;
        if (w_pop_busy) begin
            w_rd_en[r_gnt] = 1'b1;
        end else if (r_state == StIdle && !w_win_found && w_disc_found) begin
            w_rd_en[w_disc] = 1'b1;
        end
        for (int i = 0; i < NUM_VC; i++) begin
            w_cred_inc[i] = credit_val && (credit_vc == VC_W'(i));
            w_cred_dec[i] = w_pop_busy && (r_gnt == VC_W'(i));
            if (w_cred_inc[i] && !w_cred_dec[i] && r_credit[i] == CNT_W'(CREDIT_DEPTH))
                w_cred_ovf = 1'b1;
        end
        w_err_next = w_cred_ovf
                   || (r_state == StIdle && !w_win_found && w_disc_found)
                   || (w_pop_busy && w_pop_flit[30:29] == FT_HEAD);
    end

    // Pops are suppressed while reset is asserted so the FIFOs see nothing mid-reset
    assign rd_en    = rst_n ? w_rd_en : '0;
    assign out_val  = r_out_val;
    assign out_data = r_out_data;
    assign out_vc   = r_out_vc;
    assign err      = r_err;

    // Credit counters: pop decrements, return increments, both together cancel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VC; i++) r_credit[i] <= CNT_W'(CREDIT_DEPTH);
        end else begin
            for (int i = 0; i < NUM_VC; i++) begin
                if (w_cred_inc[i] && !w_cred_dec[i]) begin
                    if (r_credit[i] != CNT_W'(CREDIT_DEPTH)) r_credit[i] <= r_credit[i] + 1'b1;
                end else if (w_cred_dec[i] && !w_cred_inc[i]) begin
                    r_credit[i] <= r_credit[i] - 1'b1;
                end
            end
        end
    end

    // Arbitration FSM with registered link outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_gnt      <= '0;
            r_rr_ptr   <= '0;
            r_out_val  <= 1'b0;
            r_out_data <= '0;
            r_out_vc   <= '0;
            r_err      <= 1'b0;
        end else begin
            r_out_val <= w_pop_busy;
            r_err     <= w_err_next;
            if (w_pop_busy) begin
                r_out_data <= w_pop_flit;
                r_out_vc   <= r_gnt;
            end
            case (r_state)
                StIdle: begin
                    if (w_win_found) begin
                        r_gnt   <= w_win;
                        r_state <= StBusy;
                    end
                end
                StBusy: begin
                    if (w_pop_busy && w_pop_flit[30:29] == FT_TAIL) begin
                        r_state  <= StIdle;
                        r_rr_ptr <= w_gnt_next;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule
